// File: rtl/iodelay2_ctrl.sv
// Sequencer for a delay element's CAL/RST/CE/INC pins, tracking the tap setting it
// has commanded and honouring the element's BUSY handshake after every pulse.
module iodelay2_ctrl #(
    parameter bit          CAL_ON_RESET = 1'b1,
    parameter logic [7:0]  INIT_TAP     = 8'd0,
    parameter bit          WRAPAROUND   = 1'b1,
    parameter int unsigned GUARD        = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_count_i,
    output logic       done_o,
    output logic [7:0] tap_value_o,
    output logic       iod_cal_o,
    output logic       iod_rst_o,
    output logic       iod_ce_o,
    output logic       iod_inc_o,
    input  logic       iod_busy_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CAL_P  = 3'd1;
    localparam logic [2:0] S_CAL_W  = 3'd2;
    localparam logic [2:0] S_RST_P  = 3'd3;
    localparam logic [2:0] S_RST_W  = 3'd4;
    localparam logic [2:0] S_STEP_P = 3'd5;
    localparam logic [2:0] S_STEP_W = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    localparam logic [1:0] OP_CAL = 2'b00;
    localparam logic [1:0] OP_RST = 2'b01;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] tap_q, tap_d;
    logic [7:0] count_q, count_d;
    logic [3:0] guard_q, guard_d;
    logic       dirInc_q, dirInc_d;
    logic       startup_q, startup_d;

    logic atLimit;
    logic stepBlocked;
    logic waitDone;

    assign atLimit     = dirInc_q ? (tap_q == 8'hFF) : (tap_q == 8'h00);
    assign stepBlocked = !WRAPAROUND && atLimit;
    // The guard count expires first; only then is BUSY allowed to hold the wait state.
    assign waitDone    = (guard_q == 4'd0) && !iod_busy_i;

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        count_d   = count_q;
        guard_d   = guard_q;
        dirInc_d  = dirInc_q;
        startup_d = startup_q;
        case (state_q)
            S_IDLE: begin
                if (startup_q) begin
                    state_d = S_CAL_P;
                end else if (cmd_valid_i) begin
                    if (cmd_op_i == OP_CAL) begin
                        state_d = S_CAL_P;
                    end else if (cmd_op_i == OP_RST) begin
                        state_d = S_RST_P;
                    end else begin
                        dirInc_d = !cmd_op_i[0];
                        count_d  = cmd_count_i;
                        state_d  = (cmd_count_i == 8'd0) ? S_FIN : S_STEP_P;
                    end
                end
            end
            S_CAL_P: begin
                guard_d = GUARD_LOAD;
                state_d = S_CAL_W;
            end
            S_CAL_W: begin
                if (guard_q != 4'd0) begin
                    guard_d = guard_q - 4'd1;
                end else if (waitDone) begin
                    startup_d = 1'b0;
                    state_d   = startup_q ? S_RST_P : S_FIN;
                end
            end
            S_RST_P: begin
                tap_d   = INIT_TAP;
                guard_d = GUARD_LOAD;
                state_d = S_RST_W;
            end
            S_RST_W: begin
                if (guard_q != 4'd0) begin
                    guard_d = guard_q - 4'd1;
                end else if (waitDone) begin
                    state_d = S_FIN;
                end
            end
            S_STEP_P: begin
                // At a hard limit the step is still consumed, just without moving the tap.
                if (!stepBlocked) begin
                    tap_d = dirInc_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
                end
                count_d = count_q - 8'd1;
                guard_d = GUARD_LOAD;
                state_d = S_STEP_W;
            end
            S_STEP_W: begin
                if (guard_q != 4'd0) begin
                    guard_d = guard_q - 4'd1;
                end else if (waitDone) begin
                    state_d = (count_q != 8'd0) ? S_STEP_P : S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tap_q     <= INIT_TAP;
            count_q   <= 8'd0;
            guard_q   <= 4'd0;
            dirInc_q  <= 1'b0;
            startup_q <= CAL_ON_RESET;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            count_q   <= count_d;
            guard_q   <= guard_d;
            dirInc_q  <= dirInc_d;
            startup_q <= startup_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE) && !startup_q;
    assign done_o      = (state_q == S_FIN);
    assign tap_value_o = tap_q;
    assign iod_cal_o   = (state_q == S_CAL_P);
    assign iod_rst_o   = (state_q == S_RST_P);
    assign iod_ce_o    = (state_q == S_STEP_P) && !stepBlocked;
    assign iod_inc_o   = ((state_q == S_STEP_P) || (state_q == S_STEP_W)) && dirInc_q;

endmodule

// File: tb/tb_iodelay2_ctrl.sv
// Directed bench for iodelay2_ctrl: instance 0 uses the defaults (startup CAL, wrap),
// instance 1 has no startup calibration, saturating taps and INIT_TAP=250.
module tb_iodelay2_ctrl;

    localparam logic [1:0] OP_CAL = 2'b00;
    localparam logic [1:0] OP_RST = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    logic       clk = 1'b0;
    logic       busy = 1'b0;
    logic       rst       [2];
    logic       cmdValid  [2];
    logic [1:0] cmdOp     [2];
    logic [7:0] cmdCount  [2];
    logic       cmdReady  [2];
    logic       doneO     [2];
    logic [7:0] tapValue  [2];
    logic       iodCal    [2];
    logic       iodRst    [2];
    logic       iodCe     [2];
    logic       iodInc    [2];

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    iodelay2_ctrl dut (
        .clk_i(clk), .rst_i(rst[0]), .cmd_valid_i(cmdValid[0]), .cmd_ready_o(cmdReady[0]),
        .cmd_op_i(cmdOp[0]), .cmd_count_i(cmdCount[0]), .done_o(doneO[0]),
        .tap_value_o(tapValue[0]), .iod_cal_o(iodCal[0]), .iod_rst_o(iodRst[0]),
        .iod_ce_o(iodCe[0]), .iod_inc_o(iodInc[0]), .iod_busy_i(busy)
    );

    iodelay2_ctrl #(
        .CAL_ON_RESET(1'b0), .INIT_TAP(8'd250), .WRAPAROUND(1'b0), .GUARD(2)
    ) dutSat (
        .clk_i(clk), .rst_i(rst[1]), .cmd_valid_i(cmdValid[1]), .cmd_ready_o(cmdReady[1]),
        .cmd_op_i(cmdOp[1]), .cmd_count_i(cmdCount[1]), .done_o(doneO[1]),
        .tap_value_o(tapValue[1]), .iod_cal_o(iodCal[1]), .iod_rst_o(iodRst[1]),
        .iod_ce_o(iodCe[1]), .iod_inc_o(iodInc[1]), .iod_busy_i(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issues one command and follows it to its done pulse, recording every pin pulse.
    task automatic applyStimulus(input int d, input logic [1:0] op, input logic [7:0] cnt,
                                 input bit holdValid, output int doneAt,
                                 output logic [31:0] ceMask, output int ceCount,
                                 output int calCount, output int rstCount,
                                 output bit incBad, output bit multiBad, output bit readyBad);
        doneAt = 0; ceMask = 32'd0; ceCount = 0; calCount = 0; rstCount = 0;
        incBad = 1'b0; multiBad = 1'b0; readyBad = 1'b0;
        cmdOp[d] = op;
        cmdCount[d] = cnt;
        cmdValid[d] = 1'b1;
        step();
        if (holdValid) begin
            cmdOp[d] = OP_INC;
            cmdCount[d] = 8'd5;
        end else begin
            cmdValid[d] = 1'b0;
        end
        for (int c = 1; c <= 200; c++) begin
            if (iodCe[d]) begin
                ceCount++;
                if (c < 32) ceMask[c] = 1'b1;
            end
            if (iodCal[d]) calCount++;
            if (iodRst[d]) rstCount++;
            if ((32'(iodCal[d]) + 32'(iodRst[d]) + 32'(iodCe[d])) > 1) multiBad = 1'b1;
            if (cmdReady[d] !== 1'b0) readyBad = 1'b1;
            if (iodInc[d] !== (!doneO[d] && op == OP_INC)) incBad = 1'b1;
            if (doneO[d]) begin
                doneAt = c;
                cmdValid[d] = 1'b0;
                break;
            end
            step();
        end
        step();
    endtask

    int doneAt, ceCount, calCount, rstCount;
    logic [31:0] ceMask;
    bit incBad, multiBad, readyBad;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; cmdValid[i] = 1'b0; cmdOp[i] = 2'b00; cmdCount[i] = 8'd0;
        end
        step();
        step();
        checkOutput("reset_pins", {27'd0, iodCal[0], iodRst[0], iodCe[0], iodInc[0], doneO[0]}, 32'd0);
        checkOutput("reset_tap", tapValue[0], 32'd0);
        checkOutput("reset_ready_startup", cmdReady[0], 32'd0);
        checkOutput("reset_tap_sat", tapValue[1], 32'd250);

        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            checkOutput($sformatf("startup_cal_c%0d", c), iodCal[0], 32'(c == 1));
            checkOutput($sformatf("startup_rst_c%0d", c), iodRst[0], 32'(c == 4));
            checkOutput($sformatf("startup_done_c%0d", c), doneO[0], 32'(c == 7));
            checkOutput($sformatf("startup_ready_c%0d", c), cmdReady[0], 32'(c == 8));
            if (c == 1) begin
                checkOutput("nocal_ready_first", cmdReady[1], 32'd1);
                checkOutput("nocal_tap_first", tapValue[1], 32'd250);
            end
        end

        applyStimulus(0, OP_INC, 8'd10, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("inc10_done", doneAt, 32'd31);
        checkOutput("inc10_tap", tapValue[0], 32'd10);
        checkOutput("inc10_ce", ceCount, 32'd10);

        applyStimulus(0, OP_INC, 8'd3, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("inc3_done", doneAt, 32'd10);
        checkOutput("inc3_cemask", ceMask, 32'h92);
        checkOutput("inc3_tap", tapValue[0], 32'd13);
        checkOutput("inc3_incpin", incBad, 32'd0);
        checkOutput("inc3_ready_after", cmdReady[0], 32'd1);

        applyStimulus(0, OP_DEC, 8'd15, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("dec15_done", doneAt, 32'd46);
        checkOutput("dec15_ce", ceCount, 32'd15);
        checkOutput("dec15_tap_wrap", tapValue[0], 32'd254);
        checkOutput("dec15_incpin", incBad, 32'd0);

        applyStimulus(0, OP_INC, 8'd3, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("wrap_inc3_cemask", ceMask, 32'h92);
        checkOutput("wrap_inc3_tap", tapValue[0], 32'd1);

        applyStimulus(0, OP_INC, 8'd0, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("inc0_done", doneAt, 32'd1);
        checkOutput("inc0_ce", ceCount, 32'd0);
        checkOutput("inc0_tap", tapValue[0], 32'd1);

        applyStimulus(0, OP_DEC, 8'd2, 1'b1, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("dec2_hold_done", doneAt, 32'd7);
        checkOutput("dec2_hold_ce", ceCount, 32'd2);
        checkOutput("dec2_hold_ready", readyBad, 32'd0);
        checkOutput("dec2_hold_tap", tapValue[0], 32'd255);
        checkOutput("dec2_hold_incpin", incBad, 32'd0);
        checkOutput("dec2_idle_ready", cmdReady[0], 32'd1);

        applyStimulus(0, OP_RST, 8'd9, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("rstcmd_done", doneAt, 32'd4);
        checkOutput("rstcmd_pulses", rstCount, 32'd1);
        checkOutput("rstcmd_ce", ceCount + calCount, 32'd0);
        checkOutput("rstcmd_tap", tapValue[0], 32'd0);

        // CAL with BUSY held high well past the guard window.
        cmdOp[0] = OP_CAL;
        cmdValid[0] = 1'b1;
        step();
        cmdValid[0] = 1'b0;
        checkOutput("calbusy_pulse", iodCal[0], 32'd1);
        busy = 1'b1;
        for (int c = 2; c <= 13; c++) begin
            step();
            if (c == 12) busy = 1'b0;
            checkOutput($sformatf("calbusy_done_c%0d", c), doneO[0], 32'(c == 13));
        end
        checkOutput("calbusy_tap", tapValue[0], 32'd0);
        step();
        checkOutput("calbusy_ready", cmdReady[0], 32'd1);

        applyStimulus(1, OP_INC, 8'd4, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("sat_inc4_done", doneAt, 32'd13);
        checkOutput("sat_inc4_tap", tapValue[1], 32'd254);

        applyStimulus(1, OP_INC, 8'd3, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("sat_inc3_done", doneAt, 32'd10);
        checkOutput("sat_inc3_cemask", ceMask, 32'h2);
        checkOutput("sat_inc3_tap", tapValue[1], 32'd255);
        checkOutput("sat_inc3_incpin", incBad, 32'd0);

        applyStimulus(1, OP_INC, 8'd2, 1'b0, doneAt, ceMask, ceCount, calCount, rstCount, incBad, multiBad, readyBad);
        checkOutput("sat_limit_done", doneAt, 32'd7);
        checkOutput("sat_limit_ce", ceCount, 32'd0);
        checkOutput("sat_limit_tap", tapValue[1], 32'd255);
        checkOutput("sat_exclusive", multiBad, 32'd0);

        // Reset lands in the middle of a DEC 5 and must restart the startup sequence.
        cmdOp[0] = OP_DEC;
        cmdCount[0] = 8'd5;
        cmdValid[0] = 1'b1;
        step();
        cmdValid[0] = 1'b0;
        checkOutput("midrst_first_ce", iodCe[0], 32'd1);
        step();
        checkOutput("midrst_tap_before", tapValue[0], 32'd255);
        rst[0] = 1'b1;
        step();
        checkOutput("midrst_pins", {28'd0, iodCal[0], iodRst[0], iodCe[0], iodInc[0]}, 32'd0);
        checkOutput("midrst_tap", tapValue[0], 32'd0);
        checkOutput("midrst_done", doneO[0], 32'd0);
        checkOutput("midrst_ready", cmdReady[0], 32'd0);
        rst[0] = 1'b0;
        step();
        checkOutput("midrst_restart_cal", iodCal[0], 32'd1);
        for (int c = 2; c <= 7; c++) step();
        checkOutput("midrst_restart_done", doneO[0], 32'd1);
        step();
        checkOutput("midrst_restart_ready", cmdReady[0], 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/iodelay2_ctrl.md
IODELAY2_CTRL -- requirements
Module: iodelay2_ctrl

Interface
REQ-001 Parameter CAL_ON_RESET, default 1, meaning: run CAL then RST sequence automatically after reset release.
REQ-002 Parameter INIT_TAP, default 0, meaning: tap value loaded into tap_value by a RST sequence (0..255, matches delay element IDELAY_VALUE).
REQ-003 Parameter WRAPAROUND, default 1, meaning: 1 = tap counter wraps 255<->0, 0 = stays at limit.
REQ-004 Parameter GUARD, default 2, meaning: minimum wait cycles after any pulse before BUSY is sampled (range 1..15).
REQ-005 CLK  input  1  single clock; all logic rising-edge.
REQ-006 RST  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  controller idle, command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_op  input  2  00 CAL, 01 RST, 10 INC, 11 DEC.
REQ-010 cmd_count  input  8  step count for INC/DEC; ignored for CAL/RST.
REQ-011 done  output  1  one-cycle pulse when a command (or startup sequence) completes.
REQ-012 tap_value  output  8  controller's tracked tap setting.
REQ-013 IOD_CAL, IOD_RST, IOD_CE, IOD_INC  output  1 each  drive delay element CAL/RST/CE/INC pins.
REQ-014 IOD_BUSY  input  1  delay element BUSY.

Function
REQ-015 States SHALL be IDLE, CAL_P, CAL_W, RST_P, RST_W, STEP_P, STEP_W, FIN.
REQ-016 cmd_ready SHALL be 1 only in IDLE; command and count SHALL be registered at acceptance; inputs ignored otherwise.
REQ-017 CAL accept: IDLE->CAL_P; IOD_CAL high exactly one cycle; ->CAL_W.
REQ-018 RST accept: IDLE->RST_P; IOD_RST high exactly one cycle; ->RST_W; tap_value <= INIT_TAP on the RST_P edge.
REQ-019 *_W states SHALL wait GUARD cycles, then remain until IOD_BUSY=0, then exit; a constant-0 BUSY SHALL therefore complete after exactly GUARD cycles.
REQ-020 CAL_W exit: if in startup sequence ->RST_P, else ->FIN.
REQ-021 RST_W exit ->FIN.
REQ-022 INC/DEC with count N>0: STEP_P asserts IOD_CE one cycle with IOD_INC=1 (INC) or 0 (DEC), tap_value +/-1 same edge, remaining count -1, ->STEP_W; STEP_W exit ->STEP_P if remaining>0, else ->FIN.
REQ-023 cmd_count=0: IDLE->FIN directly, no pulses, tap_value unchanged.
REQ-024 WRAPAROUND=1: 255+1=0, 0-1=255 (8-bit modulo), CE issued.
REQ-025 WRAPAROUND=0: step at limit (255 INC, 0 DEC) SHALL issue no CE pulse, tap_value unchanged, step still consumed incl. STEP_W.
REQ-026 IOD_INC SHALL be held at its command direction throughout STEP_P/STEP_W; 0 elsewhere.
REQ-027 FIN: done=1 for one cycle, ->IDLE; cmd_ready=1 the following cycle (a command cannot be accepted in FIN).
REQ-028 Never more than one of IOD_CAL, IOD_RST, IOD_CE high in a cycle.
REQ-029 CAL SHALL NOT change tap_value.

Reset
REQ-030 RST=1 at an edge: state IDLE, all IOD_* = 0, done=0, tap_value=INIT_TAP, count cleared, regardless of current state (mid-pulse included).
REQ-031 After RST release with CAL_ON_RESET=1: first cycle enters CAL_P (startup), cmd_ready=0 until FIN; done pulses once at end.
REQ-032 CAL_ON_RESET=0: first cycle after release in IDLE with cmd_ready=1.

Verification
REQ-033 Startup, BUSY=0, GUARD=2: release RST -> IOD_CAL at cycle 1, IOD_RST at cycle 4, done at cycle 7, cmd_ready at cycle 8.
REQ-034 INC count=3 from tap 10, BUSY=0 -> three IOD_CE pulses spaced 3 cycles with IOD_INC=1, tap_value 13, one done.
REQ-035 WRAPAROUND=0, tap 254, INC count=3 -> exactly one CE pulse, tap_value 255, done after 3 steps; WRAPAROUND=1 same -> 3 pulses, tap_value 1.
REQ-036 BUSY held high 10 cycles after CAL pulse -> no exit from CAL_W until BUSY low; done follows by one cycle.
REQ-037 RST asserted during STEP_W of DEC count=5 -> next cycle all IOD_* 0, tap_value=INIT_TAP, startup sequence restarts.
REQ-038 cmd_count=0 INC -> done next cycle, no CE, tap_value unchanged; cmd_valid during busy ignored.
